// File: rtl/relu_maxpool_if.sv
// Stream bundle between the convolution core and relu_maxpool: input pixel
// strobe/data and pooled output strobe/data/frame marker.
interface relu_maxpool_if #(
    parameter int unsigned O_F_BW = 23,
    parameter int unsigned CO     = 3
);
    logic                   i_valid;
    logic [CO*O_F_BW-1:0]   i_fmap;
    logic                   o_valid;
    logic [CO*O_F_BW-1:0]   o_fmap;
    logic                   o_frame_done;

    modport slave  (input  i_valid, i_fmap, output o_valid, o_fmap, o_frame_done);
    modport master (output i_valid, i_fmap, input  o_valid, o_fmap, o_frame_done);
endinterface

// File: rtl/relu_maxpool.sv
// ReLU + 2x2/stride-2 max pooling over a raster feature-map stream, one line buffer per channel.
// Define RELU_MAXPOOL_RELU_EN to clamp negatives to 0; otherwise pooling is a pure signed max.
module relu_maxpool #(
    parameter int unsigned O_F_BW = 23,
    parameter int unsigned CO     = 3,
    parameter int unsigned IW     = 24,
    parameter int unsigned IH     = 24
) (
    input  logic          clk,
    input  logic          reset,
    relu_maxpool_if.slave bus
);
    localparam int unsigned CW  = (IW > 2) ? $clog2(IW) : 2;
    localparam int unsigned RW  = (IH > 2) ? $clog2(IH) : 2;
    localparam int unsigned LBW = (IW / 2 > 0) ? IW / 2 : 1;
    localparam int unsigned W   = CO * O_F_BW;

    // Phase is {row parity, col parity}; no separate state register.
    typedef enum logic [1:0] {
        HOLD_E   = 2'b00,
        WRITE_LB = 2'b01,
        HOLD_O   = 2'b10,
        EMIT     = 2'b11
    } phase_e;

    logic [CW-1:0]             col_q, col_d;
    logic [RW-1:0]             row_q, row_d;
    logic signed [O_F_BW-1:0]  hold_q [CO];
    logic signed [O_F_BW-1:0]  hold_d [CO];
    logic signed [O_F_BW-1:0]  lbuf_q [LBW][CO];
    logic signed [O_F_BW-1:0]  v      [CO];
    logic signed [O_F_BW-1:0]  hmax   [CO];
    logic signed [O_F_BW-1:0]  pmax   [CO];
    logic                      o_valid_q, o_valid_d;
    logic                      done_q, done_d;
    logic [W-1:0]              o_fmap_q, o_fmap_d;
    logic [CW-2:0]             lb_idx;
    logic                      last_col, last_row;
    phase_e                    phase;

    function automatic logic signed [O_F_BW-1:0] act(input logic signed [O_F_BW-1:0] x);
`ifdef RELU_MAXPOOL_RELU_EN
        return x[O_F_BW-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    assign phase    = phase_e'({row_q[0], col_q[0]});
    assign lb_idx   = col_q[CW-1:1];
    assign last_col = (col_q == CW'(IW - 1));
    assign last_row = (row_q == RW'(IH - 1));

    always_comb begin
        for (int unsigned c = 0; c < CO; c++) begin
            v[c]    = act(bus.i_fmap[c*O_F_BW +: O_F_BW]);
            hmax[c] = (hold_q[c] > v[c]) ? hold_q[c] : v[c];
            pmax[c] = (lbuf_q[lb_idx][c] > hmax[c]) ? lbuf_q[lb_idx][c] : hmax[c];
        end
    end

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        hold_d    = hold_q;
        o_valid_d = 1'b0;
        o_fmap_d  = o_fmap_q;
        done_d    = 1'b0;
        if (bus.i_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            done_d = last_col && last_row;
            case (phase)
                HOLD_E, HOLD_O: begin
                    for (int unsigned c = 0; c < CO; c++) hold_d[c] = v[c];
                end
                EMIT: begin
                    o_valid_d = 1'b1;
                    for (int unsigned c = 0; c < CO; c++) o_fmap_d[c*O_F_BW +: O_F_BW] = pmax[c];
                end
                WRITE_LB: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q     <= '0;
            row_q     <= '0;
            o_valid_q <= 1'b0;
            o_fmap_q  <= '0;
            done_q    <= 1'b0;
            for (int unsigned c = 0; c < CO; c++) hold_q[c] <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            o_valid_q <= o_valid_d;
            o_fmap_q  <= o_fmap_d;
            done_q    <= done_d;
            hold_q    <= hold_d;
        end
    end

    // Contents are don't-care after reset: every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (bus.i_valid && phase == WRITE_LB) begin
            for (int unsigned c = 0; c < CO; c++) lbuf_q[lb_idx][c] <= hmax[c];
        end
    end

    assign bus.o_valid      = o_valid_q;
    assign bus.o_fmap       = o_fmap_q;
    assign bus.o_frame_done = done_q;
endmodule

// File: tb/tb_relu_maxpool.sv
// Self-checking bench for relu_maxpool: directed frames with a per-window reference pooling model.
module tb_relu_maxpool;
    localparam int O_F_BW = 23;
    localparam int CO     = 3;
    localparam int IW     = 24;
    localparam int IH     = 24;
    localparam int W      = CO * O_F_BW;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    relu_maxpool_if #(.O_F_BW(O_F_BW), .CO(CO)) bus ();

    relu_maxpool #(.O_F_BW(O_F_BW), .CO(CO), .IW(IW), .IH(IH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int           img [IH][IW][CO];
    int           r_pos, c_pos;
    logic [W-1:0] last_exp;
    int           n_cmp, n_bad;

    function automatic int act(input int x);
`ifdef RELU_MAXPOOL_RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [W-1:0] pool(input int pr, input int pc);
        logic [W-1:0] res;
        int m, t;
        res = '0;
        for (int ch = 0; ch < CO; ch++) begin
            m = act(img[2*pr][2*pc][ch]);
            for (int dr = 0; dr < 2; dr++)
                for (int dc = 0; dc < 2; dc++) begin
                    t = act(img[2*pr+dr][2*pc+dc][ch]);
                    if (t > m) m = t;
                end
            res[ch*O_F_BW +: O_F_BW] = m[O_F_BW-1:0];
        end
        return res;
    endfunction

    function automatic logic [W-1:0] pack_px(input int r, input int c);
        logic [W-1:0] res;
        int t;
        res = '0;
        for (int ch = 0; ch < CO; ch++) begin
            t = img[r][c][ch];
            res[ch*O_F_BW +: O_F_BW] = t[O_F_BW-1:0];
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s at r=%0d c=%0d: got %h, expected %h", tag, r_pos, c_pos, got, exp);
        end
    endtask

    // One clock: drive on negedge, sample 1 time unit after the rising edge.
    task automatic pix(input logic v, input logic rst);
        logic         ev, ed;
        logic [W-1:0] ef;
        @(negedge clk);
        reset       = rst;
        bus.i_valid = v;
        bus.i_fmap  = v ? pack_px(r_pos, c_pos) : {$urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        ev = 1'b0;
        ed = 1'b0;
        ef = last_exp;
        if (rst) begin
            ef    = '0;
            r_pos = 0;
            c_pos = 0;
        end else if (v) begin
            if ((r_pos % 2 == 1) && (c_pos % 2 == 1)) begin
                ev = 1'b1;
                ef = pool(r_pos / 2, c_pos / 2);
            end
            ed = (r_pos == IH - 1) && (c_pos == IW - 1);
            c_pos++;
            if (c_pos == IW) begin
                c_pos = 0;
                r_pos = (r_pos == IH - 1) ? 0 : r_pos + 1;
            end
        end
        last_exp = ef;
        chk("o_valid", W'(bus.o_valid), W'(ev));
        chk("o_frame_done", W'(bus.o_frame_done), W'(ed));
        chk("o_fmap", bus.o_fmap, ef);
    endtask

    task automatic run(input int npix, input bit gapped);
        for (int i = 0; i < npix; i++) begin
            if (gapped) begin
                for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) pix(1'b0, 1'b0);
            end
            pix(1'b1, 1'b0);
        end
    endtask

    task automatic load_ramp(input int off);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                for (int ch = 0; ch < CO; ch++) img[r][c][ch] = r * IW + c + off;
    endtask

    task automatic load_rand();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                for (int ch = 0; ch < CO; ch++) img[r][c][ch] = $signed($urandom) >>> 9;
    endtask

    task automatic load_neg();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                img[r][c][0] = -5;
                img[r][c][1] = 7;
                img[r][c][2] = (c % 2 == 0) ? -100 : 3;
            end
    endtask

    task automatic load_maxpos(input int k);
        int vals [4];
        vals = '{1, 9, 4, 2};
        load_rand();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) img[r][c][1] = vals[((r % 2) * 2 + (c % 2) + k) % 4];
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        r_pos       = 0;
        c_pos       = 0;
        last_exp    = '0;
        bus.i_valid = 1'b0;
        bus.i_fmap  = '0;

        pix(1'b0, 1'b1);
        pix(1'b1, 1'b1);
        pix(1'b0, 1'b0);

        // Contiguous ramp, then a back-to-back offset ramp.
        load_ramp(0);
        run(IW * IH, 1'b0);
        chk("ramp_last", last_exp[O_F_BW-1:0], W'(575));
        load_ramp(1000);
        run(IW * IH, 1'b0);
        chk("b2b_last", last_exp[O_F_BW-1:0], W'(1575));

        load_neg();
        run(IW * IH, 1'b0);
`ifdef RELU_MAXPOOL_RELU_EN
        chk("neg_pool", last_exp, {23'd3, 23'd7, 23'd0});
`else
        chk("neg_pool", last_exp, {23'd3, 23'd7, 23'h7FFFFB});
`endif

        for (int k = 0; k < 4; k++) begin
            load_maxpos(k);
            run(IW * IH, 1'b0);
            chk("maxpos_ch1", W'(bus.o_fmap[O_F_BW +: O_F_BW]), W'(9));
        end

        load_rand();
        run(IW * IH, 1'b1);

        load_ramp(0);
        run(IW * IH, 1'b1);

        // Reset after 300 pixels, then a clean frame.
        load_ramp(0);
        run(300, 1'b0);
        pix(1'b1, 1'b1);
        run(IW * IH, 1'b0);

        // Reset coinciding with an odd/odd accept must cancel its output.
        load_rand();
        run(IW + 1, 1'b0);
        pix(1'b1, 1'b1);
        run(IW * IH, 1'b1);
        pix(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
